// File: rtl/sram_bank_array_ctrl_if.sv
// Request/response bundle between a streaming client and sram_bank_array_ctrl.
// Optional byte mask is present only when SRAM_BANK_WMASK_EN is defined.
interface sram_bank_array_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
`ifdef SRAM_BANK_WMASK_EN
    logic [DATA_WIDTH/8-1:0] req_wmask;
`endif
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

`ifdef SRAM_BANK_WMASK_EN
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`endif
endinterface

// File: rtl/sram_bank_array_ctrl.sv
// Banked single-port SRAM array with valid/ready request/response handshakes,
// a 2-entry response buffer and an error flag for unmapped banks.
// Optional feature macro: SRAM_BANK_WMASK_EN (per-byte write mask).
module sram_bank_array_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int BANK_DEPTH = 1024,
    parameter int NUM_BANKS  = 6
) (
    input logic                   CLK,
    input logic                   RSTB,
    sram_bank_array_ctrl_if.slave bus
);
    localparam int BANK_AW    = $clog2(BANK_DEPTH);
    localparam int SEL_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ADDR_WIDTH = SEL_W + BANK_AW;

    logic [SEL_W-1:0]      w_sel;
    logic [BANK_AW-1:0]    w_word;
    logic                  w_mapped;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_rd_acc;
    logic [NUM_BANKS-1:0]  w_bank_en;
    logic [DATA_WIDTH-1:0] w_bank_q [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_idx;
    logic                  w_rsp_valid;

    logic [1:0]            r_count;
    logic                  r_inflight;
    logic [SEL_W-1:0]      r_rsel;
    logic                  r_rerr;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic                  r_fifo_err  [2];

    assign w_sel       = bus.req_addr[ADDR_WIDTH-1:BANK_AW];
    assign w_word      = bus.req_addr[BANK_AW-1:0];
    assign w_mapped    = (32'(w_sel) < NUM_BANKS);
    // Slots are counted including the read still in the array, so a read can
    // always land in the buffer on the following edge.
    assign w_req_ready = (3'(r_count) + 3'(r_inflight)) < 3'd2;
    assign w_accept    = bus.req_valid & w_req_ready;
    assign w_rd_acc    = w_accept & ~bus.req_write;

    // One-hot bank enable; unmapped selects enable nothing.
    always_comb begin
        w_bank_en = '0;
        if (w_accept && w_mapped) begin
            w_bank_en[w_sel] = 1'b1;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] r_q;

        // Bank storage and its read register; neither is reset.
        always_ff @(posedge CLK) begin
            if (w_bank_en[b]) begin
                if (bus.req_write) begin
`ifdef SRAM_BANK_WMASK_EN
                    for (int i = 0; i < DATA_WIDTH/8; i++) begin
                        if (bus.req_wmask[i]) begin
                            r_mem[w_word][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
                        end
                    end
`else
                    r_mem[w_word] <= bus.req_wdata;
`endif
                end else begin
                    r_q <= r_mem[w_word];
                end
            end
        end

        assign w_bank_q[b] = r_q;
    end

    assign w_push      = r_inflight;
    assign w_push_data = r_rerr ? '0 : w_bank_q[r_rsel];
    assign w_rsp_valid = (r_count != 2'd0);
    assign w_pop       = w_rsp_valid & bus.rsp_ready;
    // Head is slot 0; a push lands behind whatever remains after this edge's pop.
    assign w_push_idx  = w_pop ? (r_count == 2'd2) : (r_count != 2'd0);

    // In-flight read tracking and the 2-entry shift-style response buffer.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_inflight     <= 1'b0;
            r_rsel         <= '0;
            r_rerr         <= 1'b0;
            r_count        <= 2'd0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_err[0]  <= 1'b0;
            r_fifo_err[1]  <= 1'b0;
        end else begin
            r_inflight <= w_rd_acc;
            if (w_rd_acc) begin
                r_rsel <= w_sel;
                r_rerr <= ~w_mapped;
            end
            if (w_pop) begin
                r_fifo_data[0] <= r_fifo_data[1];
                r_fifo_err[0]  <= r_fifo_err[1];
                r_fifo_data[1] <= '0;
                r_fifo_err[1]  <= 1'b0;
            end
            if (w_push) begin
                if (w_push_idx) begin
                    r_fifo_data[1] <= w_push_data;
                    r_fifo_err[1]  <= r_rerr;
                end else begin
                    r_fifo_data[0] <= w_push_data;
                    r_fifo_err[0]  <= r_rerr;
                end
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_fifo_data[0];
    assign bus.rsp_err   = r_fifo_err[0];
endmodule
